// File: rtl/wave_cmd_pkg.sv
// Shared constants and enums for the waveform command parser.
package wave_cmd_pkg;

  localparam logic [3:0] SYNC_NIBBLE = 4'hA;

  typedef enum logic [3:0] {
    OP_NOP      = 4'd0,
    OP_SET_WAVE = 4'd1,
    OP_SET_FREQ = 4'd2,
    OP_SET_AMP  = 4'd3,
    OP_ENABLE   = 4'd4,
    OP_DISABLE  = 4'd5
  } opcode_e;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_SYNC    = 2'd1,
    ERR_PAYLOAD = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PAY1 = 2'd1,
    ST_PAY2 = 2'd2
  } state_e;

  // An opcode byte is accepted only with the sync nibble and a defined operation.
  function automatic logic opcode_ok(input logic [7:0] b);
    return (b[7:4] == SYNC_NIBBLE) && (b[3:0] <= 4'd5);
  endfunction

endpackage

// File: rtl/wave_cmd_timeout.sv
// Inter-byte watchdog: counts while run is high, restarts on clear.
module wave_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 15000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expired
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (clear || !run)    cnt <= '0;
    else if (cnt != LAST)      cnt <= cnt + 1'b1;
  end

  // An arriving byte in the expiry cycle takes precedence over the timeout.
  assign expired = run && !clear && (cnt == LAST);

endmodule

// File: rtl/wave_cmd_parser.sv
// Parses SPI command frames (opcode + 0..2 payload bytes) into waveform settings.
module wave_cmd_parser
  import wave_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  command,
  input  logic        command_signal,
  output logic [1:0]  wave_sel,
  output logic [15:0] freq_word,
  output logic [7:0]  amplitude,
  output logic        out_en,
  output logic        update,
  output logic        err,
  output logic [1:0]  err_code
);
  state_e     state;
  opcode_e    op_pend;
  logic [7:0] shadow;
  logic       expired;

  wave_cmd_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (state != ST_IDLE),
    .clear   (command_signal),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_pend   <= OP_NOP;
      shadow    <= '0;
      wave_sel  <= '0;
      freq_word <= '0;
      amplitude <= '0;
      out_en    <= 1'b0;
      update    <= 1'b0;
      err       <= 1'b0;
      err_code  <= '0;
    end else begin
      update <= 1'b0;
      err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (command_signal) begin
            if (!opcode_ok(command)) begin
              err      <= 1'b1;
              err_code <= ERR_SYNC;
            end else begin
              case (opcode_e'(command[3:0]))
                OP_SET_WAVE, OP_SET_FREQ, OP_SET_AMP: begin
                  op_pend <= opcode_e'(command[3:0]);
                  state   <= ST_PAY1;
                end
                OP_ENABLE: begin
                  out_en <= 1'b1;
                  update <= 1'b1;
                end
                OP_DISABLE: begin
                  out_en <= 1'b0;
                  update <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        ST_PAY1: begin
          if (command_signal) begin
            state <= ST_IDLE;
            case (op_pend)
              OP_SET_WAVE: begin
                if (|command[7:2]) begin
                  err      <= 1'b1;
                  err_code <= ERR_PAYLOAD;
                end else begin
                  wave_sel <= command[1:0];
                  update   <= 1'b1;
                end
              end
              OP_SET_AMP: begin
                amplitude <= command;
                update    <= 1'b1;
              end
              OP_SET_FREQ: begin
                // MSB waits in the shadow so freq_word never shows half a word.
                shadow <= command;
                state  <= ST_PAY2;
              end
              default: ;
            endcase
          end else if (expired) begin
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            shadow   <= '0;
            state    <= ST_IDLE;
          end
        end
        ST_PAY2: begin
          if (command_signal) begin
            freq_word <= {shadow, command};
            update    <= 1'b1;
            shadow    <= '0;
            state     <= ST_IDLE;
          end else if (expired) begin
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            shadow   <= '0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_cmd_parser.sv
// Self-checking bench: fixed vector table, corner sequences, random frames vs a frame-level model.
module tb_wave_cmd_parser;
  localparam int N = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  command = 8'h00;
  logic        command_signal = 1'b0;
  logic [1:0]  wave_sel;
  logic [15:0] freq_word;
  logic [7:0]  amplitude;
  logic        out_en, update, err;
  logic [1:0]  err_code;

  wave_cmd_parser #(.TIMEOUT_CYCLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .command(command), .command_signal(command_signal),
    .wave_sel(wave_sel), .freq_word(freq_word), .amplitude(amplitude),
    .out_en(out_en), .update(update), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Frame-level reference: pending opcode, bytes collected, idle gap since last byte.
  int          m_op;
  logic [7:0]  m_got[$];
  int          m_gap;
  logic [1:0]  m_wave;
  logic [15:0] m_freq;
  logic [7:0]  m_amp;
  logic        m_en, m_upd, m_err;
  logic [1:0]  m_code;

  function automatic int need_bytes(int op);
    return (op == 2) ? 2 : 1;
  endfunction

  function void model_reset();
    m_op = -1; m_got.delete(); m_gap = 0;
    m_wave = 0; m_freq = 0; m_amp = 0; m_en = 0; m_upd = 0; m_err = 0; m_code = 0;
  endfunction

  function void model_step(bit cs, logic [7:0] b);
    m_upd = 0; m_err = 0;
    if (m_op >= 0) begin
      if (cs) begin
        m_gap = 0;
        m_got.push_back(b);
        if (m_got.size() == need_bytes(m_op)) begin
          if (m_op == 1) begin
            if (b > 8'd3) begin m_err = 1; m_code = 2; end
            else begin m_wave = b[1:0]; m_upd = 1; end
          end else if (m_op == 2) begin
            m_freq = {m_got[0], m_got[1]}; m_upd = 1;
          end else begin
            m_amp = b; m_upd = 1;
          end
          m_op = -1; m_got.delete();
        end
      end else begin
        m_gap++;
        if (m_gap == N) begin
          m_err = 1; m_code = 3; m_op = -1; m_got.delete();
        end
      end
    end else if (cs) begin
      if (b[7:4] != 4'hA || b[3:0] > 4'd5) begin
        m_err = 1; m_code = 1;
      end else if (b[3:0] >= 4'd1 && b[3:0] <= 4'd3) begin
        m_op = int'(b[3:0]); m_gap = 0;
      end else if (b[3:0] == 4'd4) begin
        m_en = 1; m_upd = 1;
      end else if (b[3:0] == 4'd5) begin
        m_en = 0; m_upd = 1;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("wave_sel", 32'(wave_sel), 32'(m_wave));
    check("freq_word", 32'(freq_word), 32'(m_freq));
    check("amplitude", 32'(amplitude), 32'(m_amp));
    check("out_en", 32'(out_en), 32'(m_en));
    check("update", 32'(update), 32'(m_upd));
    check("err", 32'(err), 32'(m_err));
    check("err_code", 32'(err_code), 32'(m_code));
    check("update_err_exclusive", 32'(update & err), 32'd0);
  endtask

  // Checks outputs produced by the previous cycle, then drives this cycle's inputs.
  task automatic step(input bit r, input bit cs, input logic [7:0] b);
    @(negedge clk);
    check_model();
    rst_n = !r;
    command_signal = cs;
    command = b;
    if (r) model_reset();
    else   model_step(cs, b);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit         cs;
    logic [7:0] b;
    logic [1:0] wave;
    logic [15:0] freq;
    logic [7:0] amp;
    bit         en, upd, er;
    logic [1:0] code;
  } vec_t;

  vec_t vt[$];
  int   errs;

  initial begin
    vt.push_back('{0, 8'h00, 0, 16'h0000, 8'h00, 0, 0, 0, 0});
    vt.push_back('{1, 8'hA2, 0, 16'h0000, 8'h00, 0, 0, 0, 0});
    vt.push_back('{1, 8'h12, 0, 16'h0000, 8'h00, 0, 0, 0, 0});
    vt.push_back('{1, 8'h34, 0, 16'h1234, 8'h00, 0, 1, 0, 0});
    vt.push_back('{0, 8'h00, 0, 16'h1234, 8'h00, 0, 0, 0, 0});
    vt.push_back('{1, 8'hA1, 0, 16'h1234, 8'h00, 0, 0, 0, 0});
    vt.push_back('{1, 8'h03, 3, 16'h1234, 8'h00, 0, 1, 0, 0});
    vt.push_back('{1, 8'hA1, 3, 16'h1234, 8'h00, 0, 0, 0, 0});
    vt.push_back('{1, 8'h07, 3, 16'h1234, 8'h00, 0, 0, 1, 2});
    vt.push_back('{1, 8'h52, 3, 16'h1234, 8'h00, 0, 0, 1, 1});
    vt.push_back('{1, 8'hA4, 3, 16'h1234, 8'h00, 1, 1, 0, 1});
    vt.push_back('{1, 8'hA5, 3, 16'h1234, 8'h00, 0, 1, 0, 1});
    vt.push_back('{1, 8'hA3, 3, 16'h1234, 8'h00, 0, 0, 0, 1});
    vt.push_back('{1, 8'hFF, 3, 16'h1234, 8'hFF, 0, 1, 0, 1});
    vt.push_back('{1, 8'hA4, 3, 16'h1234, 8'hFF, 1, 1, 0, 1});
    vt.push_back('{0, 8'h00, 3, 16'h1234, 8'hFF, 1, 0, 0, 1});
    vt.push_back('{1, 8'hA0, 3, 16'h1234, 8'hFF, 1, 0, 0, 1});
    vt.push_back('{1, 8'hAF, 3, 16'h1234, 8'hFF, 1, 0, 1, 1});

    model_reset();
    step(1, 0, 8'h00);
    step(1, 0, 8'h00);

    foreach (vt[i]) begin
      step(0, vt[i].cs, vt[i].b);
      settle();
      check($sformatf("vec%0d_wave", i), 32'(wave_sel), 32'(vt[i].wave));
      check($sformatf("vec%0d_freq", i), 32'(freq_word), 32'(vt[i].freq));
      check($sformatf("vec%0d_amp", i), 32'(amplitude), 32'(vt[i].amp));
      check($sformatf("vec%0d_en", i), 32'(out_en), 32'(vt[i].en));
      check($sformatf("vec%0d_upd", i), 32'(update), 32'(vt[i].upd));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].er));
      check($sformatf("vec%0d_code", i), 32'(err_code), 32'(vt[i].code));
    end

    // Timeout mid SET_FREQ: one err, code 3, freq untouched.
    step(0, 1, 8'hA2);
    step(0, 1, 8'h12);
    errs = 0;
    for (int k = 0; k < N + 3; k++) begin
      step(0, 0, 8'h00);
      settle();
      if (err) errs++;
    end
    check("timeout_err_pulses", 32'(errs), 32'd1);
    check("timeout_code", 32'(err_code), 32'd3);
    check("timeout_freq_kept", 32'(freq_word), 32'h1234);
    step(0, 1, 8'hA3);
    step(0, 1, 8'h80);
    settle();
    check("amp_after_timeout", 32'(amplitude), 32'h80);

    // Byte arriving in the expiry cycle wins over the timeout.
    step(0, 1, 8'hA2);
    step(0, 1, 8'h56);
    for (int k = 0; k < N - 1; k++) step(0, 0, 8'h00);
    step(0, 1, 8'h78);
    settle();
    check("expiry_byte_freq", 32'(freq_word), 32'h5678);
    check("expiry_byte_no_err", 32'(err), 32'd0);
    check("expiry_byte_upd", 32'(update), 32'd1);

    // Reset mid-frame: next byte is an opcode.
    step(0, 1, 8'hA2);
    step(0, 1, 8'h56);
    step(1, 0, 8'h00);
    step(1, 0, 8'h00);
    step(1, 0, 8'h00);
    step(0, 1, 8'h78);
    settle();
    check("rst_frame_err", 32'(err), 32'd1);
    check("rst_frame_code", 32'(err_code), 32'd1);
    check("rst_frame_freq", 32'(freq_word), 32'd0);
    check("rst_frame_out", 32'({wave_sel, amplitude, out_en}), 32'd0);

    // Random frames with occasional long gaps to exercise the watchdog.
    for (int k = 0; k < 3000; k++) begin
      logic [7:0] b;
      if ($urandom_range(0, 3) == 0) b = 8'($urandom);
      else if ($urandom_range(0, 2) == 0) b = 8'($urandom_range(0, 3));
      else b = {4'hA, 4'($urandom_range(0, 6))};
      if ($urandom_range(0, 15) == 0) begin
        int gap = $urandom_range(N - 2, N + 2);
        for (int g = 0; g < gap; g++) step(0, 0, 8'h00);
      end
      if ($urandom_range(0, 199) == 0) step(1, 0, 8'h00);
      else step(0, $urandom_range(0, 9) < 6, b);
    end
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
